// File: rtl/ej32_pkg.sv
// Shared definitions for the ej32 arithmetic unit: opcodes, width typedefs, defaults.
package ej32_pkg;

  localparam int DSZ_DEF      = 32;
  localparam int SS_DEPTH_DEF = 64;

  typedef logic [31:0] DU;
  typedef logic [15:0] IU;
  typedef logic [7:0]  U8;

  typedef enum logic [7:0] {
    OP_ICONST_M1 = 8'h02,
    OP_ICONST_0  = 8'h03,
    OP_ICONST_1  = 8'h04,
    OP_ICONST_2  = 8'h05,
    OP_ICONST_3  = 8'h06,
    OP_ICONST_4  = 8'h07,
    OP_ICONST_5  = 8'h08,
    OP_POP       = 8'h57,
    OP_POP2      = 8'h58,
    OP_DUP       = 8'h59,
    OP_SWAP      = 8'h5F,
    OP_IADD      = 8'h60,
    OP_ISUB      = 8'h64,
    OP_IMUL      = 8'h68,
    OP_IDIV      = 8'h6C,
    OP_IREM      = 8'h70,
    OP_INEG      = 8'h74,
    OP_ISHL      = 8'h78,
    OP_ISHR      = 8'h7A,
    OP_IUSHR     = 8'h7C,
    OP_IAND      = 8'h7E,
    OP_IOR       = 8'h80,
    OP_IXOR      = 8'h82
  } opcode_e;

  // True for the two opcodes served by the iterative divider.
  function automatic logic is_div(input U8 c);
    return (c == OP_IDIV) || (c == OP_IREM);
  endfunction

endpackage

// File: rtl/ej32_au_if.sv
// Decoder <-> arithmetic unit bus: opcode/TOS in, new TOS/NOS/busy out.
interface ej32_au_if import ej32_pkg::*; #(
  parameter int DSZ = DSZ_DEF
);
  logic           au_en;
  logic [7:0]     code;
  logic [DSZ-1:0] t;
  logic [DSZ-1:0] au_t_o;
  logic           au_t_x;
  logic [DSZ-1:0] s_o;
  logic           div_bsy_o;

  modport master (
    output au_en, code, t,
    input  au_t_o, au_t_x, s_o, div_bsy_o
  );

  modport slave (
    input  au_en, code, t,
    output au_t_o, au_t_x, s_o, div_bsy_o
  );
endinterface

// File: rtl/ej32_div.sv
// Iterative signed divider: restoring division on magnitudes, one quotient bit per cycle.
module ej32_div import ej32_pkg::*; #(
  parameter int DSZ = DSZ_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_start,
  input  logic           i_ack,
  input  logic [DSZ-1:0] i_dividend,
  input  logic [DSZ-1:0] i_divisor,
  output logic           o_busy,
  output logic           o_done,
  output logic [DSZ-1:0] o_quo,
  output logic [DSZ-1:0] o_rem
);
  localparam int CW = $clog2(DSZ);

  logic           r_busy;
  logic           r_done;
  logic           r_neg_q;
  logic           r_neg_r;
  logic           r_dz;
  logic [CW-1:0]  r_cnt;
  logic [DSZ-1:0] r_quo;
  logic [DSZ-1:0] r_rem;
  logic [DSZ-1:0] r_dvs;
  logic [DSZ-1:0] r_dvd_raw;

  logic [DSZ-1:0] w_dvd_abs;
  logic [DSZ-1:0] w_dvs_abs;
  logic [DSZ:0]   w_sh;
  logic [DSZ:0]   w_diff;

  assign w_dvd_abs = i_dividend[DSZ-1] ? ('0 - i_dividend) : i_dividend;
  assign w_dvs_abs = i_divisor[DSZ-1]  ? ('0 - i_divisor)  : i_divisor;
  assign w_sh      = {r_rem, r_quo[DSZ-1]};
  assign w_diff    = w_sh - {1'b0, r_dvs};

  // Start latches operands, busy shifts one bit per cycle, done holds until acknowledged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_dz      <= 1'b0;
      r_cnt     <= '0;
      r_quo     <= '0;
      r_rem     <= '0;
      r_dvs     <= '0;
      r_dvd_raw <= '0;
    end else if (i_start) begin
      r_busy    <= 1'b1;
      r_done    <= 1'b0;
      r_cnt     <= CW'(DSZ - 1);
      r_quo     <= w_dvd_abs;
      r_rem     <= '0;
      r_dvs     <= w_dvs_abs;
      r_neg_q   <= i_dividend[DSZ-1] ^ i_divisor[DSZ-1];
      r_neg_r   <= i_dividend[DSZ-1];
      r_dz      <= (i_divisor == '0);
      r_dvd_raw <= i_dividend;
    end else if (r_busy) begin
      if (!w_diff[DSZ]) begin
        r_rem <= w_diff[DSZ-1:0];
        r_quo <= {r_quo[DSZ-2:0], 1'b1};
      end else begin
        r_rem <= w_sh[DSZ-1:0];
        r_quo <= {r_quo[DSZ-2:0], 1'b0};
      end
      if (r_cnt == '0) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end else begin
        r_cnt <= r_cnt - CW'(1);
      end
    end else if (i_ack) begin
      r_done <= 1'b0;
    end
  end

  // Divide-by-zero is overridden here; MIN/-1 falls out of the unsigned magnitude path.
  assign o_quo  = r_dz ? '1 : (r_neg_q ? ('0 - r_quo) : r_quo);
  assign o_rem  = r_dz ? r_dvd_raw : (r_neg_r ? ('0 - r_rem) : r_rem);
  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: rtl/ej32_au.sv
// ej32 arithmetic unit: data stack (NOS and below), single-cycle ALU ops, iterative divide.
module ej32_au import ej32_pkg::*; #(
  parameter int DSZ      = DSZ_DEF,
  parameter int SS_DEPTH = SS_DEPTH_DEF
) (
  input  logic    clk,
  input  logic    rst,
  ej32_au_if.slave au
);
  localparam int SPW = $clog2(SS_DEPTH);

  logic [DSZ-1:0] r_ss [SS_DEPTH];
  logic [SPW-1:0] r_sp;

  logic [SPW-1:0] w_sp_p1;
  logic [SPW-1:0] w_sp_m1;
  logic [SPW-1:0] w_sp_nxt;
  logic           w_we;
  logic [SPW-1:0] w_waddr;
  logic [DSZ-1:0] w_nos;
  logic [DSZ-1:0] w_nos2;
  logic [DSZ-1:0] w_kval;
  logic [DSZ-1:0] w_alu;
  logic [DSZ-1:0] w_res;
  logic [4:0]     w_shamt;
  logic           w_x;
  logic           w_run;
  logic           w_div_start;
  logic           w_div_ack;
  logic           w_div_busy;
  logic           w_div_done;
  logic [DSZ-1:0] w_quo;
  logic [DSZ-1:0] w_rem;

  assign w_sp_p1 = r_sp + SPW'(1);
  assign w_sp_m1 = r_sp - SPW'(1);
  assign w_nos   = r_ss[r_sp];
  assign w_nos2  = r_ss[w_sp_m1];
  assign w_kval  = DSZ'(au.code) - DSZ'(3);
  assign w_shamt = au.t[4:0];
  assign w_run   = au.au_en & rst;

  // A finished result must be consumed before the same held opcode may start a new divide.
  assign w_div_start = w_run & is_div(au.code) & ~w_div_busy & ~w_div_done;

  ej32_div #(.DSZ(DSZ)) u_div (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_div_start),
    .i_ack      (w_div_ack),
    .i_dividend (w_nos),
    .i_divisor  (au.t),
    .o_busy     (w_div_busy),
    .o_done     (w_div_done),
    .o_quo      (w_quo),
    .o_rem      (w_rem)
  );

  // Binary NOS OP TOS results.
  always_comb begin
    w_alu = '0;
    case (au.code)
      OP_IADD:  w_alu = w_nos + au.t;
      OP_ISUB:  w_alu = w_nos - au.t;
      OP_IMUL:  w_alu = w_nos * au.t;
      OP_IAND:  w_alu = w_nos & au.t;
      OP_IOR:   w_alu = w_nos | au.t;
      OP_IXOR:  w_alu = w_nos ^ au.t;
      OP_ISHL:  w_alu = w_nos << w_shamt;
      OP_ISHR:  w_alu = $unsigned($signed(w_nos) >>> w_shamt);
      OP_IUSHR: w_alu = w_nos >> w_shamt;
      default:  w_alu = '0;
    endcase
  end

  // Opcode decode: new TOS, update request, stack pointer and stack write.
  always_comb begin
    w_x       = 1'b0;
    w_res     = '0;
    w_sp_nxt  = r_sp;
    w_we      = 1'b0;
    w_waddr   = r_sp;
    w_div_ack = 1'b0;
    if (w_run && !w_div_busy) begin
      case (au.code)
        OP_ICONST_M1, OP_ICONST_0, OP_ICONST_1, OP_ICONST_2,
        OP_ICONST_3, OP_ICONST_4, OP_ICONST_5: begin
          w_x      = 1'b1;
          w_res    = w_kval;
          w_sp_nxt = w_sp_p1;
          w_we     = 1'b1;
          w_waddr  = w_sp_p1;
        end
        OP_DUP: begin
          w_x      = 1'b1;
          w_res    = au.t;
          w_sp_nxt = w_sp_p1;
          w_we     = 1'b1;
          w_waddr  = w_sp_p1;
        end
        OP_POP: begin
          w_x      = 1'b1;
          w_res    = w_nos;
          w_sp_nxt = w_sp_m1;
        end
        OP_POP2: begin
          w_x      = 1'b1;
          w_res    = w_nos2;
          w_sp_nxt = r_sp - SPW'(2);
        end
        OP_SWAP: begin
          w_x     = 1'b1;
          w_res   = w_nos;
          w_we    = 1'b1;
          w_waddr = r_sp;
        end
        OP_INEG: begin
          w_x   = 1'b1;
          w_res = '0 - au.t;
        end
        OP_IADD, OP_ISUB, OP_IMUL, OP_IAND, OP_IOR, OP_IXOR,
        OP_ISHL, OP_ISHR, OP_IUSHR: begin
          w_x      = 1'b1;
          w_res    = w_alu;
          w_sp_nxt = w_sp_m1;
        end
        OP_IDIV, OP_IREM: begin
          if (w_div_done) begin
            w_x       = 1'b1;
            w_res     = (au.code == OP_IDIV) ? w_quo : w_rem;
            w_sp_nxt  = w_sp_m1;
            w_div_ack = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Stack pointer, wrapping modulo the stack depth.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_sp <= '0;
    else      r_sp <= w_sp_nxt;
  end

  // Stack storage: one write port, contents survive reset.
  always_ff @(posedge clk) begin
    if (w_we) r_ss[w_waddr] <= au.t;
  end

  assign au.au_t_o    = w_res;
  assign au.au_t_x    = w_x;
  assign au.s_o       = w_nos;
  assign au.div_bsy_o = w_div_start | w_div_busy;

endmodule

// File: tb/tb_ej32_au.sv
// Self-checking bench for ej32_au: directed corner cases plus randomized op stream vs. a stack model.
module tb_ej32_au;
  import ej32_pkg::*;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;
  bit   filled;

  logic [31:0] mss [64];
  int          msp;

  ej32_au_if #(.DSZ(32)) bus ();

  ej32_au #(.DSZ(32), .SS_DEPTH(64)) dut (
    .clk (clk),
    .rst (rst),
    .au  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference divide per JVM rules.
  function automatic logic [31:0] ref_div(input logic [31:0] s, input logic [31:0] d, input bit want_rem);
    int sd, td, q, r;
    sd = s;
    td = d;
    if (td == 0) begin
      q = -1; r = sd;
    end else if (sd == 32'sh80000000 && td == -1) begin
      q = sd; r = 0;
    end else begin
      q = sd / td; r = sd % td;
    end
    return want_rem ? r : q;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    bus.au_en = 1'b1;
    bus.code  = OP_IADD;
    rst = 1'b0;
    #1;
    chk("rst_bsy", 32'(bus.div_bsy_o), 32'd0);
    chk("rst_x", 32'(bus.au_t_x), 32'd0);
    chk("rst_sp", 32'(dut.r_sp), 32'd0);
    bus.au_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    msp = 0;
  endtask

  // One decoder cycle (or a full divide) with model-predicted outputs and state.
  task automatic run_op(input logic [7:0] c, input logic [31:0] tv, input bit en, input int drop_at);
    logic [31:0] s, s2, ev;
    bit ex, dv, fin;
    int dsp, wk, n;
    s  = mss[msp];
    s2 = mss[(msp + 63) % 64];
    ex = 0; dv = 0; ev = '0; dsp = 0; wk = 0;
    if (en) begin
      case (c)
        8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08: begin
          ex = 1; ev = 32'(int'(c) - 3); dsp = 1; wk = 1;
        end
        8'h59: begin ex = 1; ev = tv; dsp = 1; wk = 1; end
        8'h57: begin ex = 1; ev = s; dsp = -1; end
        8'h58: begin ex = 1; ev = s2; dsp = -2; end
        8'h5F: begin ex = 1; ev = s; wk = 2; end
        8'h74: begin ex = 1; ev = 32'd0 - tv; end
        8'h60: begin ex = 1; ev = s + tv; dsp = -1; end
        8'h64: begin ex = 1; ev = s - tv; dsp = -1; end
        8'h68: begin ex = 1; ev = s * tv; dsp = -1; end
        8'h7E: begin ex = 1; ev = s & tv; dsp = -1; end
        8'h80: begin ex = 1; ev = s | tv; dsp = -1; end
        8'h82: begin ex = 1; ev = s ^ tv; dsp = -1; end
        8'h78: begin ex = 1; ev = s << tv[4:0]; dsp = -1; end
        8'h7A: begin ex = 1; ev = $signed(s) >>> tv[4:0]; dsp = -1; end
        8'h7C: begin ex = 1; ev = s >> tv[4:0]; dsp = -1; end
        8'h6C: begin ex = 1; dv = 1; ev = ref_div(s, tv, 1'b0); dsp = -1; end
        8'h70: begin ex = 1; dv = 1; ev = ref_div(s, tv, 1'b1); dsp = -1; end
        default: ;
      endcase
    end
    @(negedge clk);
    bus.au_en = en;
    bus.code  = c;
    bus.t     = tv;
    #1;
    if (filled) chk("s_o", bus.s_o, mss[msp]);
    if (!dv) begin
      chk("x", 32'(bus.au_t_x), 32'(ex));
      chk("bsy_idle", 32'(bus.div_bsy_o), 32'd0);
      if (ex && filled) chk("tos", bus.au_t_o, ev);
    end else begin
      chk("div_bsy_start", 32'(bus.div_bsy_o), 32'd1);
      chk("div_x_start", 32'(bus.au_t_x), 32'd0);
      n = 1; fin = 0;
      for (int i = 1; i < 40 && !fin; i++) begin
        @(negedge clk);
        if (drop_at > 0 && i == drop_at)     bus.au_en = 1'b0;
        if (drop_at > 0 && i == drop_at + 4) bus.au_en = 1'b1;
        #1;
        if (bus.div_bsy_o) begin
          n++;
          chk("div_x_busy", 32'(bus.au_t_x), 32'd0);
        end else begin
          fin = 1;
        end
      end
      if (!fin) chk("div_timeout", 32'd0, 32'd1);
      chk("div_bsy_len", 32'(n), 32'd33);
      chk("div_x_done", 32'(bus.au_t_x), 32'd1);
      chk("div_res", bus.au_t_o, ev);
    end
    @(posedge clk);
    if (wk == 1) mss[(msp + 1) % 64] = tv;
    if (wk == 2) mss[msp] = tv;
    msp = (msp + dsp + 64) % 64;
    #1;
    chk("sp", 32'(dut.r_sp), 32'(msp));
  endtask

  logic [7:0] oplist [0:25] = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                                8'h57, 8'h58, 8'h59, 8'h5F, 8'h60, 8'h64, 8'h68,
                                8'h6C, 8'h70, 8'h74, 8'h78, 8'h7A, 8'h7C, 8'h7E,
                                8'h80, 8'h82, 8'h00, 8'h09, 8'hFF};

  initial begin
    logic [7:0]  c;
    logic [31:0] tv;
    int          sel;
    n_total = 0; n_bad = 0; filled = 0; msp = 0;
    for (int i = 0; i < 64; i++) mss[i] = '0;
    rst = 1'b0;
    bus.au_en = 1'b0; bus.code = 8'h00; bus.t = '0;

    // Stack wrap: 65 pushes from reset land on sp=1 and fill every entry.
    do_reset();
    for (int i = 0; i < 65; i++) run_op(OP_DUP, $urandom, 1'b1, 0);
    chk("wrap_sp", 32'(dut.r_sp), 32'd1);
    filled = 1;

    // Underflow: pop after reset wraps to 63.
    do_reset();
    run_op(OP_POP, 32'h0, 1'b1, 0);
    chk("pop_wrap_sp", 32'(dut.r_sp), 32'd63);

    // iconst_3 then iadd with TOS 7.
    do_reset();
    run_op(OP_ICONST_3, 32'd7, 1'b1, 0);
    run_op(OP_IADD, 32'd3, 1'b1, 0);
    chk("iadd_sp0", 32'(dut.r_sp), 32'd0);

    // Shifts by 31 on 0x80000000.
    run_op(OP_DUP, 32'h80000000, 1'b1, 0);
    run_op(OP_ISHR, 32'd31, 1'b1, 0);
    run_op(OP_DUP, 32'h80000000, 1'b1, 0);
    run_op(OP_IUSHR, 32'd31, 1'b1, 0);

    // Divider corners; one run drops au_en mid-divide.
    run_op(OP_DUP, 32'hFFFFFFF9, 1'b1, 0);
    run_op(OP_IDIV, 32'd2, 1'b1, 0);
    run_op(OP_DUP, 32'hFFFFFFF9, 1'b1, 0);
    run_op(OP_IREM, 32'd2, 1'b1, 6);
    run_op(OP_DUP, 32'd5, 1'b1, 0);
    run_op(OP_IDIV, 32'd0, 1'b1, 0);
    run_op(OP_DUP, 32'd5, 1'b1, 0);
    run_op(OP_IREM, 32'd0, 1'b1, 0);
    run_op(OP_DUP, 32'h80000000, 1'b1, 0);
    run_op(OP_IDIV, 32'hFFFFFFFF, 1'b1, 0);
    run_op(OP_DUP, 32'h80000000, 1'b1, 0);
    run_op(OP_IREM, 32'hFFFFFFFF, 1'b1, 0);
    run_op(OP_DUP, 32'hFFFFFFF9, 1'b1, 0);
    run_op(OP_IDIV, 32'd0, 1'b1, 0);

    // Reset ten cycles into a divide: busy drops at once, no stale result afterwards.
    run_op(OP_DUP, 32'hFFFFFFF9, 1'b1, 0);
    @(negedge clk);
    bus.au_en = 1'b1; bus.code = OP_IDIV; bus.t = 32'd2;
    #1;
    chk("abort_bsy_start", 32'(bus.div_bsy_o), 32'd1);
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_bsy", 32'(bus.div_bsy_o), 32'd0);
    chk("abort_x", 32'(bus.au_t_x), 32'd0);
    bus.au_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    msp = 0;
    run_op(OP_IDIV, 32'd3, 1'b1, 0);

    // Randomized op stream.
    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 25);
      c   = oplist[sel];
      tv  = $urandom;
      if (c == OP_IDIV || c == OP_IREM) begin
        case ($urandom_range(0, 3))
          0: tv = 32'd0;
          1: tv = 32'hFFFFFFFF;
          2: tv = 32'($urandom_range(1, 9));
          default: ;
        endcase
      end
      run_op(c, tv, ($urandom_range(0, 9) != 0), 0);
    end

    bus.au_en = 1'b0;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
